// File: rtl/alu_gpr_datapath.sv
// ---------------------------------------------------------------------------
// alu_gpr_datapath
//
// Execution core of the multi-cycle TSC CPU: a 4 x WORD_SIZE general purpose
// register file, a combinational WORD_SIZE ALU and the ALU function decoder.
// The controller supplies register indices, write strobes and ALU operands;
// this block returns register read data, the decoded ALU function and the
// ALU result. Register writes only take effect at instruction end (commit).
//
// Ports
//   clk          in   1          rising-edge clock for all state
//   reset_n      in   1          async active-low reset, clears GPR[0..3]
//   commit       in   1          instruction-end strobe, gates the GPR write
//   reg_write    in   1          instruction wants a register write
//   rs, rt       in   2          read port 1 / read port 2 indices
//   wr_reg       in   2          write destination (rt or rd)
//   wr_data      in   WORD_SIZE  write data
//   link_write   in   1          JAL/JRL: destination forced to GPR[2]
//   rd_data1     out  WORD_SIZE  GPR[rs], combinational
//   rd_data2     out  WORD_SIZE  GPR[rt], combinational
//   opcode       in   4          instruction opcode
//   inst_func    in   6          R-type function field
//   fetch_phase  in   1          IF/ID PC increment: ALU forced to ADD
//   alu_a, alu_b in   WORD_SIZE  ALU operands
//   alu_func     out  3          decoded ALU function
//   alu_result   out  WORD_SIZE  ALU result, combinational, modulo 2^WORD_SIZE
// ---------------------------------------------------------------------------
module alu_gpr_datapath #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 commit,
    input  logic                 reg_write,
    input  logic [1:0]           rs,
    input  logic [1:0]           rt,
    input  logic [1:0]           wr_reg,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 link_write,
    output logic [WORD_SIZE-1:0] rd_data1,
    output logic [WORD_SIZE-1:0] rd_data2,
    input  logic [3:0]           opcode,
    input  logic [5:0]           inst_func,
    input  logic                 fetch_phase,
    input  logic [WORD_SIZE-1:0] alu_a,
    input  logic [WORD_SIZE-1:0] alu_b,
    output logic [2:0]           alu_func,
    output logic [WORD_SIZE-1:0] alu_result
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORR = 3'd3,
        ALU_NOT = 3'd4,
        ALU_TCP = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    localparam logic [3:0]           OPC_RTYPE = 4'd15;
    localparam logic [3:0]           OPC_ORI   = 4'd5;
    localparam logic [1:0]           LINK_REG  = 2'd2;
    localparam logic [WORD_SIZE-1:0] ONE       = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    logic [WORD_SIZE-1:0] gpr [4];
    logic [1:0]           wr_dest;
    logic                 wr_en;

    assign wr_dest = link_write ? LINK_REG : wr_reg;
    // reg_write may be held for the whole instruction; only the commit edge writes.
    assign wr_en   = commit && reg_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                gpr[i] <= '0;
            end
        end else if (wr_en) begin
            gpr[wr_dest] <= wr_data;
        end
    end

    // No bypass: a read in the write cycle sees the pre-edge value.
    assign rd_data1 = gpr[rs];
    assign rd_data2 = gpr[rt];

    // -----------------------------------------------------------------------
    // ALU function decode
    // -----------------------------------------------------------------------
    alu_op_t func_sel;

    always_comb begin
        func_sel = ALU_ADD;
        if (fetch_phase) begin
            func_sel = ALU_ADD;
        end else if (opcode == OPC_RTYPE) begin
            // Arithmetic R-type functions are 0..7; WWD/JPR/JRL/HLT use ADD.
            if (inst_func[5:3] == 3'b000) begin
                func_sel = alu_op_t'(inst_func[2:0]);
            end else begin
                func_sel = ALU_ADD;
            end
        end else if (opcode == OPC_ORI) begin
            func_sel = ALU_ORR;
        end else begin
            // Branches, ADI, LHI, LWD, SWD, JMP, JAL and unused opcodes.
            func_sel = ALU_ADD;
        end
    end

    assign alu_func = func_sel;

    // -----------------------------------------------------------------------
    // ALU
    // -----------------------------------------------------------------------
    always_comb begin
        alu_result = '0;
        case (func_sel)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_ORR: alu_result = alu_a | alu_b;
            ALU_NOT: alu_result = ~alu_a;
            ALU_TCP: alu_result = (~alu_a) + ONE;
            ALU_SHL: alu_result = {alu_a[WORD_SIZE-2:0], 1'b0};
            ALU_SHR: alu_result = {alu_a[WORD_SIZE-1], alu_a[WORD_SIZE-1:1]};
            default: alu_result = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_gpr_datapath.sv
// ---------------------------------------------------------------------------
// tb_alu_gpr_datapath
//
// Directed stimulus with hand-computed expectations. Each stimulus step
// drives the inputs just after a rising edge and queues what each output
// should read; the monitor drains the queue on the following falling edge.
// ---------------------------------------------------------------------------
module tb_alu_gpr_datapath;

    localparam int W = 16;

    localparam int K_RD1  = 0;
    localparam int K_RD2  = 1;
    localparam int K_RES  = 2;
    localparam int K_FUNC = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          commit;
    logic          reg_write;
    logic [1:0]    rs;
    logic [1:0]    rt;
    logic [1:0]    wr_reg;
    logic [W-1:0]  wr_data;
    logic          link_write;
    logic [W-1:0]  rd_data1;
    logic [W-1:0]  rd_data2;
    logic [3:0]    opcode;
    logic [5:0]    inst_func;
    logic          fetch_phase;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_func;
    logic [W-1:0]  alu_result;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    int        q_kind [$];
    logic [15:0] q_exp [$];
    string     q_name [$];

    alu_gpr_datapath #(.WORD_SIZE(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .commit      (commit),
        .reg_write   (reg_write),
        .rs          (rs),
        .rt          (rt),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .link_write  (link_write),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .opcode      (opcode),
        .inst_func   (inst_func),
        .fetch_phase (fetch_phase),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_func    (alu_func),
        .alu_result  (alu_result)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input int kind, input logic [15:0] exp, input string name);
        q_kind.push_back(kind);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    // Move to just after the next rising edge, where new inputs are applied.
    task automatic next_step();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            while (q_kind.size() > 0) begin
                int          k;
                logic [15:0] e;
                logic [15:0] act;
                string       nm;
                k  = q_kind.pop_front();
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                case (k)
                    K_RD1:   act = rd_data1;
                    K_RD2:   act = rd_data2;
                    K_RES:   act = alu_result;
                    default: act = {13'd0, alu_func};
                endcase
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: test did not complete, got timeout expected completion");
            $fatal(1, "timeout");
        end
    end

    // ALU vectors for a=8001, b=0001 via R-type functions 0..7
    logic [15:0] alu_exp [8];

    initial begin
        alu_exp[0] = 16'h8002; alu_exp[1] = 16'h8000;
        alu_exp[2] = 16'h0001; alu_exp[3] = 16'h8001;
        alu_exp[4] = 16'h7FFE; alu_exp[5] = 16'h7FFF;
        alu_exp[6] = 16'h0002; alu_exp[7] = 16'hC000;

        reset_n = 1'b0; commit = 1'b0; reg_write = 1'b0; rs = 2'd0; rt = 2'd0;
        wr_reg = 2'd0; wr_data = '0; link_write = 1'b0; opcode = 4'd0;
        inst_func = 6'd0; fetch_phase = 1'b0; alu_a = '0; alu_b = '0;

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        rs = 2'd0; rt = 2'd3;
        expect_out(K_RD1, 16'h0000, "reset_gpr0");
        expect_out(K_RD2, 16'h0000, "reset_gpr3");

        // Write gating: reg_write without commit holds the old value
        next_step();
        reg_write = 1'b1; wr_reg = 2'd1; wr_data = 16'h1234; commit = 1'b0; rs = 2'd1;
        expect_out(K_RD1, 16'h0000, "gate_before");
        next_step();
        commit = 1'b1;
        expect_out(K_RD1, 16'h0000, "gate_no_commit");
        next_step();
        commit = 1'b0;
        expect_out(K_RD1, 16'h1234, "gate_commit");

        // commit without reg_write does not write
        next_step();
        commit = 1'b1; reg_write = 1'b0; wr_reg = 2'd1; wr_data = 16'hDEAD;
        next_step();
        commit = 1'b0;
        expect_out(K_RD1, 16'h1234, "commit_no_regwrite");

        // Preload GPR[3] and GPR[0]
        next_step();
        commit = 1'b1; reg_write = 1'b1; wr_reg = 2'd3; wr_data = 16'h0333;
        next_step();
        wr_reg = 2'd0; wr_data = 16'hA5A5;
        next_step();
        commit = 1'b0; reg_write = 1'b0;
        rs = 2'd3; rt = 2'd0;
        expect_out(K_RD1, 16'h0333, "gpr3_written");
        expect_out(K_RD2, 16'hA5A5, "gpr0_written");

        // Link write redirects to GPR[2]
        next_step();
        commit = 1'b1; reg_write = 1'b1; link_write = 1'b1; wr_reg = 2'd3; wr_data = 16'h0042;
        rs = 2'd2; rt = 2'd3;
        expect_out(K_RD1, 16'h0000, "link_rdw_old");
        next_step();
        commit = 1'b0; reg_write = 1'b0; link_write = 1'b0;
        expect_out(K_RD1, 16'h0042, "link_gpr2");
        expect_out(K_RD2, 16'h0333, "link_gpr3_kept");

        // ALU through R-type decode
        for (int f = 0; f < 8; f++) begin
            next_step();
            opcode = 4'd15; inst_func = 6'(f); fetch_phase = 1'b0;
            alu_a = 16'h8001; alu_b = 16'h0001;
            expect_out(K_FUNC, 16'(f), $sformatf("rtype_func_%0d", f));
            expect_out(K_RES, alu_exp[f], $sformatf("alu_func_%0d", f));
        end

        // Wrap-around
        next_step();
        inst_func = 6'd0; alu_a = 16'hFFFF; alu_b = 16'h0001;
        expect_out(K_RES, 16'h0000, "add_wrap");
        next_step();
        inst_func = 6'd1; alu_a = 16'h0000; alu_b = 16'h0001;
        expect_out(K_RES, 16'hFFFF, "sub_wrap");

        // Decode priorities
        next_step();
        opcode = 4'd15; inst_func = 6'd6; fetch_phase = 1'b1;
        alu_a = 16'h8001; alu_b = 16'h0001;
        expect_out(K_FUNC, 16'd0, "fetch_forces_add");
        expect_out(K_RES, 16'h8002, "fetch_add_result");
        next_step();
        fetch_phase = 1'b0; opcode = 4'd5; inst_func = 6'd2;
        expect_out(K_FUNC, 16'd3, "ori_orr");
        expect_out(K_RES, 16'h8001, "ori_result");
        next_step();
        opcode = 4'd7;
        expect_out(K_FUNC, 16'd0, "lwd_add");
        next_step();
        opcode = 4'd15; inst_func = 6'd28;
        expect_out(K_FUNC, 16'd0, "wwd_add");
        next_step();
        inst_func = 6'd14;
        expect_out(K_FUNC, 16'd0, "rtype_func14_add");

        // Asynchronous reset mid-cycle, with a pending write that must be ignored
        next_step();
        rs = 2'd0; rt = 2'd1;
        commit = 1'b1; reg_write = 1'b1; wr_reg = 2'd1; wr_data = 16'h7777;
        #1;
        reset_n = 1'b0;
        expect_out(K_RD1, 16'h0000, "async_reset_gpr0");
        expect_out(K_RD2, 16'h0000, "async_reset_gpr1");
        next_step();
        rs = 2'd2; rt = 2'd3;
        expect_out(K_RD1, 16'h0000, "reset_hold_gpr2");
        expect_out(K_RD2, 16'h0000, "reset_hold_gpr3");
        next_step();
        rs = 2'd1;
        expect_out(K_RD1, 16'h0000, "reset_write_ignored");
        commit = 1'b0; reg_write = 1'b0;

        @(negedge clk);
        #1;
        if (q_kind.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_kind.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
